rv32i_decode_execute_unit: RTL and testbench
============================================

Name: rv32i_decode_execute_unit

Overview:
- Single-cycle RV32I decode/execute core slice: 32x32 register file, instruction decoder and ALU/branch unit.
- Takes the fetched instruction and PC from the program counter/fetch logic.
- Returns branch and jump redirects to the counter.
- Drives load/store and register-write control toward the writeback stage; the writeback stage feeds register writes back in.

Parameters:
- DATA_LEN, 32, datapath/register width.
- ADDR_LEN, 32, PC/address width.

Ports:
- clk  in  1  clock; register file writes on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- inst_i  in  32  instruction for the current PC.
- pc_i  in  32  current PC.
- rf_wen_i  in  1  register write enable from writeback.
- rf_waddr_i  in  5  register write address.
- rf_wdata_i  in  32  register write data.
- branch_request_o  out  1  conditional branch taken.
- branch_target_o  out  32  pc_i + B-immediate.
- jmp_flag_o  out  1  jal/jalr.
- jmp_target_o  out  32  jump target.
- wd_o  out  1  instruction writes rd.
- wreg_o  out  5  rd index.
- alu_result_o  out  32  ALU result, or load/store address.
- mem_wen_o  out  1  store.
- mem_wdata_o  out  32  rs2 value, for stores.
- store_type_o  out  2  00 none, 01 sb, 10 sh, 11 sw.
- load_type_o  out  3  000 none, 001 lb, 010 lh, 011 lw, 100 lbu, 101 lhu.
- ebreak_o  out  1  inst_i == 0x00100073.
- invalid_o  out  1  unsupported encoding.

Behaviour:
- Register file:
  - 32 entries; x0 reads 0 always.
  - Two asynchronous read ports addressed by inst_i[19:15] and inst_i[24:20].
  - Write on posedge clk when rf_wen_i=1 and rf_waddr_i!=0.
  - rst low clears all entries to 0 immediately and blocks writes.
  - No write-to-read bypass: reading the address being written returns the old value until the edge.
- Decode/execute: purely combinational, zero latency.
- Immediates: I, S, B, U, J forms per RV32I, sign-extended.
- LUI: result = U-imm.
- AUIPC: result = pc_i + U-imm.
- JAL: result = pc_i+4; jmp_target_o = pc_i + J-imm; jmp_flag_o=1.
- JALR: result = pc_i+4; jmp_target_o = (rs1+I-imm) & ~1; jmp_flag_o=1.
- Branches (beq, bne, blt, bge, bltu, bgeu):
  - wd_o=0; branch_request_o = condition true.
  - Signed compares for blt/bge, unsigned for bltu/bgeu.
  - branch_target_o valid regardless of outcome.
- OP-IMM: addi, slti, sltiu, xori, ori, andi, slli, srli, srai.
  - Shift amount is inst[24:20]; srai uses funct7 0100000.
- OP: add, sub, sll, slt, sltu, xor, srl, sra, or, and.
  - Shift amount is rs2[4:0].
- Loads: result = rs1+I-imm; wd_o=1; load_type_o set.
- Stores: result = rs1+S-imm; mem_wen_o=1; wd_o=0; store_type_o set.
- Unsupported opcode/funct combinations:
  - invalid_o=1; wd_o, mem_wen_o, branch_request_o, jmp_flag_o all 0.
  - load_type_o=000, store_type_o=00.
- ebreak: ebreak_o=1, invalid_o=0, no side effects.
- wd_o=0 whenever rd=0 (x0 writes suppressed at source).
- While rst low, forced to 0: wd_o, mem_wen_o, branch_request_o, jmp_flag_o, ebreak_o, invalid_o, load_type_o, store_type_o.
- All arithmetic is modulo 2^32; no overflow traps.

Test Plan:
- Reset: rst=0, then rf_wen_i=1 with waddr=1, wdata=0xDEADBEEF over an edge -> x1 reads 0; release rst -> all regs 0, control outputs 0.
- Writeback then ALU: write x1=5, x2=7; inst_i=0x002081B3 (add x3,x1,x2) -> alu_result_o=12, wd_o=1, wreg_o=3; write x0=9 -> x0 still reads 0.
- Branch: pc_i=0x80000000, x1=5, inst_i=0x00108463 (beq x1,x1,8) -> branch_request_o=1, branch_target_o=0x80000008, wd_o=0.
- Jump: pc_i=0x80000000, inst_i=0x010000EF (jal x1,16) -> jmp_flag_o=1, jmp_target_o=0x80000010, alu_result_o=0x80000004.
- Store and immediates:
  - x1=0x100, x2=0xAB, inst_i=0x0020A223 (sw x2,4(x1)) -> mem_wen_o=1, alu_result_o=0x104, mem_wdata_o=0xAB, store_type_o=11.
  - inst_i=0x123452B7 (lui) -> alu_result_o=0x12345000.
  - x1=0x80000000, inst_i=0x4010D213 (srai x4,x1,1) -> alu_result_o=0xC0000000.
- Illegal/ebreak: inst_i=0xFFFFFFFF -> invalid_o=1, all writes/jumps off; inst_i=0x00100073 -> ebreak_o=1, invalid_o=0.

Source files
------------

// File: rtl/rv32i_decode_execute_unit.sv
`default_nettype none
// ============================================================================
// Module      : rv32i_decode_execute_unit
// Description : Single-cycle RV32I decode/execute slice with a 32x32 register
//               file, a combinational decoder and an ALU/branch unit.
// Revision    : 1.0 - initial release
// ============================================================================
module rv32i_decode_execute_unit #(
  parameter int DATA_LEN = 32,
  parameter int ADDR_LEN = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         inst_i,
  input  logic [ADDR_LEN-1:0] pc_i,
  input  logic                rf_wen_i,
  input  logic [4:0]          rf_waddr_i,
  input  logic [DATA_LEN-1:0] rf_wdata_i,
  output logic                branch_request_o,
  output logic [ADDR_LEN-1:0] branch_target_o,
  output logic                jmp_flag_o,
  output logic [ADDR_LEN-1:0] jmp_target_o,
  output logic                wd_o,
  output logic [4:0]          wreg_o,
  output logic [DATA_LEN-1:0] alu_result_o,
  output logic                mem_wen_o,
  output logic [DATA_LEN-1:0] mem_wdata_o,
  output logic [1:0]          store_type_o,
  output logic [2:0]          load_type_o,
  output logic                ebreak_o,
  output logic                invalid_o
);

  localparam logic [6:0]  c_OP_LUI    = 7'b0110111;
  localparam logic [6:0]  c_OP_AUIPC  = 7'b0010111;
  localparam logic [6:0]  c_OP_JAL    = 7'b1101111;
  localparam logic [6:0]  c_OP_JALR   = 7'b1100111;
  localparam logic [6:0]  c_OP_BRANCH = 7'b1100011;
  localparam logic [6:0]  c_OP_LOAD   = 7'b0000011;
  localparam logic [6:0]  c_OP_STORE  = 7'b0100011;
  localparam logic [6:0]  c_OP_IMM    = 7'b0010011;
  localparam logic [6:0]  c_OP_REG    = 7'b0110011;
  localparam logic [6:0]  c_OP_SYSTEM = 7'b1110011;
  localparam logic [31:0] c_EBREAK    = 32'h0010_0073;
  localparam logic [6:0]  c_F7_BASE   = 7'b0000000;
  localparam logic [6:0]  c_F7_ALT    = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_t;

  // Shared funct3 -> ALU operation mapping for OP and OP-IMM.
  function automatic alu_op_t f_alu_op(input logic [2:0] funct3, input logic alt);
    alu_op_t op;
    case (funct3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  // Instruction fields
  logic [6:0] w_opcode;
  logic [4:0] w_rd;
  logic [2:0] w_funct3;
  logic [4:0] w_rs1;
  logic [4:0] w_rs2;
  logic [6:0] w_funct7;

  assign w_opcode = inst_i[6:0];
  assign w_rd     = inst_i[11:7];
  assign w_funct3 = inst_i[14:12];
  assign w_rs1    = inst_i[19:15];
  assign w_rs2    = inst_i[24:20];
  assign w_funct7 = inst_i[31:25];

  logic [DATA_LEN-1:0] w_imm_i;
  logic [DATA_LEN-1:0] w_imm_s;
  logic [DATA_LEN-1:0] w_imm_b;
  logic [DATA_LEN-1:0] w_imm_u;
  logic [DATA_LEN-1:0] w_imm_j;

  assign w_imm_i = {{(DATA_LEN-12){inst_i[31]}}, inst_i[31:20]};
  assign w_imm_s = {{(DATA_LEN-12){inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
  assign w_imm_b = {{(DATA_LEN-13){inst_i[31]}}, inst_i[31], inst_i[7],
                    inst_i[30:25], inst_i[11:8], 1'b0};
  assign w_imm_u = {{(DATA_LEN-32){inst_i[31]}}, inst_i[31:12], 12'b0};
  assign w_imm_j = {{(DATA_LEN-21){inst_i[31]}}, inst_i[31], inst_i[19:12],
                    inst_i[20], inst_i[30:21], 1'b0};

  // Register file: async clear, write on rising edge, x0 hardwired to zero
  logic [DATA_LEN-1:0] r_regs [32];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) begin
        r_regs[i] <= '0;
      end
    end else if (rf_wen_i && (rf_waddr_i != 5'd0)) begin
      r_regs[rf_waddr_i] <= rf_wdata_i;
    end
  end

  logic [DATA_LEN-1:0] w_rs1_val;
  logic [DATA_LEN-1:0] w_rs2_val;

  assign w_rs1_val = (w_rs1 == 5'd0) ? '0 : r_regs[w_rs1];
  assign w_rs2_val = (w_rs2 == 5'd0) ? '0 : r_regs[w_rs2];

  // Decoder
  alu_op_t             w_alu_op;
  logic [DATA_LEN-1:0] w_alu_a;
  logic [DATA_LEN-1:0] w_alu_b;
  logic                w_wd;
  logic                w_mem_wen;
  logic [1:0]          w_store_type;
  logic [2:0]          w_load_type;
  logic                w_is_branch;
  logic                w_is_jal;
  logic                w_is_jalr;
  logic                w_ebreak;
  logic                w_invalid;

  always_comb begin
    w_alu_op     = ALU_ADD;
    w_alu_a      = w_rs1_val;
    w_alu_b      = w_imm_i;
    w_wd         = 1'b0;
    w_mem_wen    = 1'b0;
    w_store_type = 2'b00;
    w_load_type  = 3'b000;
    w_is_branch  = 1'b0;
    w_is_jal     = 1'b0;
    w_is_jalr    = 1'b0;
    w_ebreak     = 1'b0;
    w_invalid    = 1'b0;
    case (w_opcode)
      c_OP_LUI: begin
        w_alu_a = '0;
        w_alu_b = w_imm_u;
        w_wd    = 1'b1;
      end
      c_OP_AUIPC: begin
        w_alu_a = pc_i;
        w_alu_b = w_imm_u;
        w_wd    = 1'b1;
      end
      c_OP_JAL: begin
        w_alu_a  = pc_i;
        w_alu_b  = DATA_LEN'(4);
        w_wd     = 1'b1;
        w_is_jal = 1'b1;
      end
      c_OP_JALR: begin
        if (w_funct3 == 3'b000) begin
          w_alu_a   = pc_i;
          w_alu_b   = DATA_LEN'(4);
          w_wd      = 1'b1;
          w_is_jalr = 1'b1;
        end else begin
          w_invalid = 1'b1;
        end
      end
      c_OP_BRANCH: begin
        if ((w_funct3 == 3'b010) || (w_funct3 == 3'b011)) begin
          w_invalid = 1'b1;
        end else begin
          w_is_branch = 1'b1;
        end
      end
      c_OP_LOAD: begin
        case (w_funct3)
          3'b000:  w_load_type = 3'b001;
          3'b001:  w_load_type = 3'b010;
          3'b010:  w_load_type = 3'b011;
          3'b100:  w_load_type = 3'b100;
          3'b101:  w_load_type = 3'b101;
          default: w_invalid   = 1'b1;
        endcase
        w_wd = ~w_invalid;
      end
      c_OP_STORE: begin
        w_alu_b = w_imm_s;
        case (w_funct3)
          3'b000:  w_store_type = 2'b01;
          3'b001:  w_store_type = 2'b10;
          3'b010:  w_store_type = 2'b11;
          default: w_invalid    = 1'b1;
        endcase
        w_mem_wen = ~w_invalid;
      end
      c_OP_IMM: begin
        // Only the shift forms constrain funct7; srai is the sole alternate.
        w_alu_op = f_alu_op(w_funct3, (w_funct3 == 3'b101) && w_funct7[5]);
        if (w_funct3 == 3'b001) begin
          w_invalid = (w_funct7 != c_F7_BASE);
        end else if (w_funct3 == 3'b101) begin
          w_invalid = (w_funct7 != c_F7_BASE) && (w_funct7 != c_F7_ALT);
        end
        w_wd = ~w_invalid;
      end
      c_OP_REG: begin
        w_alu_b  = w_rs2_val;
        w_alu_op = f_alu_op(w_funct3, w_funct7[5]);
        w_invalid = !((w_funct7 == c_F7_BASE) ||
                      ((w_funct7 == c_F7_ALT) &&
                       ((w_funct3 == 3'b000) || (w_funct3 == 3'b101))));
        w_wd = ~w_invalid;
      end
      c_OP_SYSTEM: begin
        if (inst_i == c_EBREAK) begin
          w_ebreak = 1'b1;
        end else begin
          w_invalid = 1'b1;
        end
      end
      default: begin
        w_invalid = 1'b1;
      end
    endcase
  end

  // ALU
  logic [DATA_LEN-1:0] w_alu_result;

  always_comb begin
    w_alu_result = '0;
    case (w_alu_op)
      ALU_ADD:  w_alu_result = w_alu_a + w_alu_b;
      ALU_SUB:  w_alu_result = w_alu_a - w_alu_b;
      ALU_SLL:  w_alu_result = w_alu_a << w_alu_b[4:0];
      ALU_SLT:  w_alu_result = {{(DATA_LEN-1){1'b0}}, ($signed(w_alu_a) < $signed(w_alu_b))};
      ALU_SLTU: w_alu_result = {{(DATA_LEN-1){1'b0}}, (w_alu_a < w_alu_b)};
      ALU_XOR:  w_alu_result = w_alu_a ^ w_alu_b;
      ALU_SRL:  w_alu_result = w_alu_a >> w_alu_b[4:0];
      ALU_SRA:  w_alu_result = $signed(w_alu_a) >>> w_alu_b[4:0];
      ALU_OR:   w_alu_result = w_alu_a | w_alu_b;
      ALU_AND:  w_alu_result = w_alu_a & w_alu_b;
      default:  w_alu_result = '0;
    endcase
  end

  // Branch comparator
  logic w_eq;
  logic w_lt;
  logic w_ltu;
  logic w_branch_cond;

  assign w_eq  = (w_rs1_val == w_rs2_val);
  assign w_lt  = ($signed(w_rs1_val) < $signed(w_rs2_val));
  assign w_ltu = (w_rs1_val < w_rs2_val);

  always_comb begin
    w_branch_cond = 1'b0;
    case (w_funct3)
      3'b000:  w_branch_cond = w_eq;
      3'b001:  w_branch_cond = ~w_eq;
      3'b100:  w_branch_cond = w_lt;
      3'b101:  w_branch_cond = ~w_lt;
      3'b110:  w_branch_cond = w_ltu;
      3'b111:  w_branch_cond = ~w_ltu;
      default: w_branch_cond = 1'b0;
    endcase
  end

  logic [ADDR_LEN-1:0] w_jalr_sum;
  assign w_jalr_sum = w_rs1_val + w_imm_i;

  // Control outputs are gated by reset; data outputs are left free-running.
  assign branch_request_o = rst & w_is_branch & w_branch_cond;
  assign branch_target_o  = pc_i + w_imm_b;
  assign jmp_flag_o       = rst & (w_is_jal | w_is_jalr);
  assign jmp_target_o     = w_is_jalr ? (w_jalr_sum & {{(ADDR_LEN-1){1'b1}}, 1'b0})
                                      : (pc_i + w_imm_j);
  assign wd_o             = rst & w_wd & (w_rd != 5'd0);
  assign wreg_o           = w_rd;
  assign alu_result_o     = w_alu_result;
  assign mem_wen_o        = rst & w_mem_wen;
  assign mem_wdata_o      = w_rs2_val;
  assign store_type_o     = rst ? w_store_type : 2'b00;
  assign load_type_o      = rst ? w_load_type : 3'b000;
  assign ebreak_o         = rst & w_ebreak;
  assign invalid_o        = rst & w_invalid;

endmodule
`default_nettype wire

// File: tb/tb_rv32i_decode_execute_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_rv32i_decode_execute_unit
// Description : Directed and randomized bench for rv32i_decode_execute_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rv32i_decode_execute_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst_i;
  logic [31:0] pc_i;
  logic        rf_wen_i;
  logic [4:0]  rf_waddr_i;
  logic [31:0] rf_wdata_i;
  logic        branch_request_o;
  logic [31:0] branch_target_o;
  logic        jmp_flag_o;
  logic [31:0] jmp_target_o;
  logic        wd_o;
  logic [4:0]  wreg_o;
  logic [31:0] alu_result_o;
  logic        mem_wen_o;
  logic [31:0] mem_wdata_o;
  logic [1:0]  store_type_o;
  logic [2:0]  load_type_o;
  logic        ebreak_o;
  logic        invalid_o;

  always #5 clk = ~clk;

  rv32i_decode_execute_unit #(.DATA_LEN(32), .ADDR_LEN(32)) dut (
    .clk              (clk),
    .rst              (rst),
    .inst_i           (inst_i),
    .pc_i             (pc_i),
    .rf_wen_i         (rf_wen_i),
    .rf_waddr_i       (rf_waddr_i),
    .rf_wdata_i       (rf_wdata_i),
    .branch_request_o (branch_request_o),
    .branch_target_o  (branch_target_o),
    .jmp_flag_o       (jmp_flag_o),
    .jmp_target_o     (jmp_target_o),
    .wd_o             (wd_o),
    .wreg_o           (wreg_o),
    .alu_result_o     (alu_result_o),
    .mem_wen_o        (mem_wen_o),
    .mem_wdata_o      (mem_wdata_o),
    .store_type_o     (store_type_o),
    .load_type_o      (load_type_o),
    .ebreak_o         (ebreak_o),
    .invalid_o        (invalid_o)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] m_regs [32];

  typedef struct packed {
    logic        br;
    logic        br_valid;
    logic [31:0] bt;
    logic        jmp;
    logic [31:0] jt;
    logic        wd;
    logic [4:0]  wreg;
    logic        res_valid;
    logic [31:0] res;
    logic        mwen;
    logic [31:0] mwd;
    logic [1:0]  st;
    logic [2:0]  lt;
    logic        ebreak;
    logic        inv;
  } exp_t;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  function automatic logic [31:0] alu_ref(input logic [2:0] f3, input logic alt,
                                          input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    case (f3)
      3'd0: r = alt ? a - b : a + b;
      3'd1: r = a << b[4:0];
      3'd2: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: r = (a < b) ? 32'd1 : 32'd0;
      3'd4: r = a ^ b;
      3'd5: begin
        if (alt) r = $signed(a) >>> b[4:0];
        else     r = a >> b[4:0];
      end
      3'd6: r = a | b;
      default: r = a & b;
    endcase
    return r;
  endfunction

  function automatic exp_t model(input logic [31:0] inst, input logic [31:0] pc);
    exp_t e;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] a, b, hi, top7, i_imm, s_imm, b_imm, u_imm, j_imm;
    op = inst[6:0];
    f3 = inst[14:12];
    f7 = inst[31:25];
    a  = m_regs[inst[19:15]];
    b  = m_regs[inst[24:20]];
    hi    = $signed(inst) >>> 31;
    top7  = $signed(inst) >>> 25;
    i_imm = $signed(inst) >>> 20;
    s_imm = (top7 << 5) | 32'(inst[11:7]);
    b_imm = (hi << 12) | (32'(inst[7]) << 11) | (32'(inst[30:25]) << 5) | (32'(inst[11:8]) << 1);
    u_imm = inst & 32'hFFFF_F000;
    j_imm = (hi << 20) | (32'(inst[19:12]) << 12) | (32'(inst[20]) << 11) | (32'(inst[30:21]) << 1);
    e = '0;
    e.inv  = 1'b1;
    e.wreg = inst[11:7];
    e.mwd  = b;
    e.bt   = pc + b_imm;
    case (op)
      7'h37: begin e.inv = 0; e.wd = 1; e.res_valid = 1; e.res = u_imm; end
      7'h17: begin e.inv = 0; e.wd = 1; e.res_valid = 1; e.res = pc + u_imm; end
      7'h6F: begin
        e.inv = 0; e.wd = 1; e.jmp = 1; e.jt = pc + j_imm;
        e.res_valid = 1; e.res = pc + 4;
      end
      7'h67: if (f3 == 0) begin
        e.inv = 0; e.wd = 1; e.jmp = 1; e.jt = (a + i_imm) & ~32'd1;
        e.res_valid = 1; e.res = pc + 4;
      end
      7'h63: if (f3 != 2 && f3 != 3) begin
        e.inv = 0; e.br_valid = 1;
        case (f3)
          3'd0: e.br = (a == b);
          3'd1: e.br = (a != b);
          3'd4: e.br = ($signed(a) < $signed(b));
          3'd5: e.br = ($signed(a) >= $signed(b));
          3'd6: e.br = (a < b);
          default: e.br = (a >= b);
        endcase
      end
      7'h03: if (f3 <= 2 || f3 == 4 || f3 == 5) begin
        e.inv = 0; e.wd = 1; e.res_valid = 1; e.res = a + i_imm;
        e.lt = (f3 <= 2) ? 3'(f3 + 1) : f3;
      end
      7'h23: if (f3 <= 2) begin
        e.inv = 0; e.mwen = 1; e.res_valid = 1; e.res = a + s_imm;
        e.st = 2'(f3 + 1);
      end
      7'h13: if ((f3 == 1 && f7 == 0) || (f3 == 5 && (f7 == 0 || f7 == 7'h20)) ||
                 (f3 != 1 && f3 != 5)) begin
        e.inv = 0; e.wd = 1; e.res_valid = 1;
        e.res = alu_ref(f3, (f3 == 5) && (f7 == 7'h20), a, i_imm);
      end
      7'h33: if (f7 == 0 || (f7 == 7'h20 && (f3 == 0 || f3 == 5))) begin
        e.inv = 0; e.wd = 1; e.res_valid = 1;
        e.res = alu_ref(f3, f7 == 7'h20, a, b);
      end
      7'h73: if (inst == 32'h0010_0073) begin e.inv = 0; e.ebreak = 1; end
      default: ;
    endcase
    if (inst[11:7] == 0) e.wd = 1'b0;
    return e;
  endfunction

  task automatic check_model(input string tag);
    exp_t e;
    e = model(inst_i, pc_i);
    chk({tag, " branch_request"}, branch_request_o, e.br);
    chk({tag, " jmp_flag"}, jmp_flag_o, e.jmp);
    chk({tag, " wd"}, wd_o, e.wd);
    chk({tag, " mem_wen"}, mem_wen_o, e.mwen);
    chk({tag, " store_type"}, store_type_o, e.st);
    chk({tag, " load_type"}, load_type_o, e.lt);
    chk({tag, " ebreak"}, ebreak_o, e.ebreak);
    chk({tag, " invalid"}, invalid_o, e.inv);
    if (e.br_valid)  chk({tag, " branch_target"}, branch_target_o, e.bt);
    if (e.jmp)       chk({tag, " jmp_target"}, jmp_target_o, e.jt);
    if (e.res_valid) chk({tag, " alu_result"}, alu_result_o, e.res);
    if (e.wd)        chk({tag, " wreg"}, wreg_o, e.wreg);
    if (e.mwen)      chk({tag, " mem_wdata"}, mem_wdata_o, e.mwd);
  endtask

  task automatic rf_write(input logic [4:0] addr, input logic [31:0] data);
    rf_wen_i   = 1'b1;
    rf_waddr_i = addr;
    rf_wdata_i = data;
    @(posedge clk);
    #2;
    rf_wen_i = 1'b0;
    if (rst && addr != 0) m_regs[addr] = data;
  endtask

  function automatic logic [31:0] addi_x5(input int r);
    return {12'd0, 5'(r), 3'd0, 5'd5, 7'h13};
  endfunction

  task automatic set_inst(input logic [31:0] inst, input logic [31:0] pc);
    inst_i = inst;
    pc_i   = pc;
    #1;
  endtask

  function automatic logic [31:0] rand_val();
    case ($urandom_range(0, 4))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'(($urandom_range(0, 3)));
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [6:0] ops [10] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h73};
    logic [31:0] w;
    logic [6:0]  f7s [3] = '{7'h00, 7'h20, 7'h01};
    w = $urandom;
    case ($urandom_range(0, 19))
      0: return w;
      1: return 32'h0010_0073;
      default: begin
        w[6:0] = ops[$urandom_range(0, 9)];
        if (w[6:0] == 7'h13 || w[6:0] == 7'h33) w[31:25] = f7s[$urandom_range(0, 2)];
        return w;
      end
    endcase
  endfunction

  initial begin
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    rst        = 1'b0;
    rf_wen_i   = 1'b0;
    rf_waddr_i = 5'd0;
    rf_wdata_i = 32'd0;
    inst_i     = 32'h0000_0013;
    pc_i       = 32'd0;
    @(posedge clk);
    #2;

    // Writes are blocked and controls forced low while in reset
    rf_write(5'd1, 32'hDEAD_BEEF);
    set_inst(addi_x5(1), 32'd0);
    chk("rst x1 read", alu_result_o, 32'd0);
    chk("rst wd forced", wd_o, 1'b0);
    set_inst(32'hFFFF_FFFF, 32'd0);
    chk("rst invalid forced", invalid_o, 1'b0);
    set_inst(32'h0010_0073, 32'd0);
    chk("rst ebreak forced", ebreak_o, 1'b0);
    set_inst(32'h010000EF, 32'd0);
    chk("rst jmp forced", jmp_flag_o, 1'b0);

    rst = 1'b1;
    for (int i = 0; i < 32; i++) begin
      set_inst(addi_x5(i), 32'd0);
      chk("post-rst reg zero", alu_result_o, 32'd0);
    end
    set_inst(32'h0000_0013, 32'd0);
    chk("nop wd", wd_o, 1'b0);
    chk("nop invalid", invalid_o, 1'b0);
    chk("nop mem_wen", mem_wen_o, 1'b0);
    chk("nop jmp", jmp_flag_o, 1'b0);
    chk("nop branch", branch_request_o, 1'b0);

    // Writeback then ALU
    rf_write(5'd1, 32'd5);
    rf_write(5'd2, 32'd7);
    set_inst(32'h0020_81B3, 32'd0);
    chk("add result", alu_result_o, 32'd12);
    chk("add wd", wd_o, 1'b1);
    chk("add wreg", wreg_o, 5'd3);
    rf_write(5'd0, 32'd9);
    set_inst(addi_x5(0), 32'd0);
    chk("x0 stays zero", alu_result_o, 32'd0);

    // No write-to-read bypass
    set_inst(addi_x5(1), 32'd0);
    rf_wen_i = 1'b1; rf_waddr_i = 5'd1; rf_wdata_i = 32'h55;
    #1;
    chk("no bypass old value", alu_result_o, 32'd5);
    @(posedge clk);
    #2;
    rf_wen_i = 1'b0;
    m_regs[1] = 32'h55;
    chk("write visible after edge", alu_result_o, 32'h55);

    // Branch
    rf_write(5'd1, 32'd5);
    set_inst(32'h0010_8463, 32'h8000_0000);
    chk("beq taken", branch_request_o, 1'b1);
    chk("beq target", branch_target_o, 32'h8000_0008);
    chk("beq wd", wd_o, 1'b0);

    // Jump
    set_inst(32'h0100_00EF, 32'h8000_0000);
    chk("jal flag", jmp_flag_o, 1'b1);
    chk("jal target", jmp_target_o, 32'h8000_0010);
    chk("jal link", alu_result_o, 32'h8000_0004);

    // Store and immediates
    rf_write(5'd1, 32'h100);
    rf_write(5'd2, 32'hAB);
    set_inst(32'h0020_A223, 32'd0);
    chk("sw mem_wen", mem_wen_o, 1'b1);
    chk("sw addr", alu_result_o, 32'h104);
    chk("sw wdata", mem_wdata_o, 32'hAB);
    chk("sw type", store_type_o, 2'b11);
    chk("sw wd", wd_o, 1'b0);
    set_inst(32'h1234_52B7, 32'd0);
    chk("lui result", alu_result_o, 32'h1234_5000);
    rf_write(5'd1, 32'h8000_0000);
    set_inst(32'h4010_D213, 32'd0);
    chk("srai result", alu_result_o, 32'hC000_0000);

    // Illegal and ebreak
    set_inst(32'hFFFF_FFFF, 32'd0);
    chk("illegal invalid", invalid_o, 1'b1);
    chk("illegal wd", wd_o, 1'b0);
    chk("illegal mem_wen", mem_wen_o, 1'b0);
    chk("illegal jmp", jmp_flag_o, 1'b0);
    chk("illegal branch", branch_request_o, 1'b0);
    chk("illegal load_type", load_type_o, 3'b000);
    chk("illegal store_type", store_type_o, 2'b00);
    set_inst(32'h0010_0073, 32'd0);
    chk("ebreak flag", ebreak_o, 1'b1);
    chk("ebreak invalid", invalid_o, 1'b0);
    chk("ebreak wd", wd_o, 1'b0);

    // Randomized instructions against the reference model
    for (int r = 0; r < 60; r++) begin
      rf_write(5'($urandom_range(0, 31)), rand_val());
      rf_write(5'($urandom_range(1, 7)), rand_val());
      for (int k = 0; k < 8; k++) begin
        set_inst(rand_inst(), $urandom & 32'hFFFF_FFFC);
        check_model("rand");
      end
    end

    // Asynchronous clear mid-run, then writes blocked
    rst = 1'b0;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    #1;
    for (int i = 1; i < 8; i++) begin
      set_inst(addi_x5(i), 32'd0);
      chk("async clear", alu_result_o, 32'd0);
    end
    rf_write(5'd3, 32'h1234);
    set_inst(addi_x5(3), 32'd0);
    chk("write blocked in reset", alu_result_o, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
